fifo_wr_arbiter: RTL

- Round-robin, burst-locked arbiter that shares the write port of the asynchronous FIFO among NUM_REQ requesters in the write clock domain.
- Selects one owner, passes that owner's data to the FIFO write port, and gates every beat with the FIFO's full flag.
- Rotates ownership after MAX_BURST beats, or earlier if the owner drops its request.
- Sits between the write-domain producers and the FIFO's w_en/data_in/full pins.

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters, the arbiter and the FIFO write pins.
// The slave modport is the arbiter's view; the master modport is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_full;
  logic                          fifo_w_en;
  logic [DATA_WIDTH-1:0]         fifo_data;
  logic                          busy;
  logic [ID_W-1:0]               owner_id;

  modport master (
    output req, req_data, fifo_full,
    input  gnt, fifo_w_en, fifo_data, busy, owner_id
  );

  modport slave (
    input  req, req_data, fifo_full,
    output gnt, fifo_w_en, fifo_data, busy, owner_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing the async FIFO write port among NUM_REQ producers.
// Optional macro ARB_STALL_CNT_EN adds a saturating 16-bit full-stall counter output.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic               wclk,
  input  logic               wrst,
`ifdef ARB_STALL_CNT_EN
  output logic [15:0]        stall_cnt,
`endif
  fifo_wr_arbiter_if.slave   bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, owner, owner_inc, pick;
  logic [ID_W:0]     idx;
  logic              pick_vld;
  logic [CNT_W-1:0]  beat_cnt;
  logic              owner_req, beat, release_now;
  logic [NUM_REQ-1:0]    gnt_c;
  logic [DATA_WIDTH-1:0] data_c;

  // Cyclic first-set search starting at rr_ptr; the single subtract is enough
  // because rr_ptr + k < 2*NUM_REQ, so non-power-of-two NUM_REQ wraps correctly.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!pick_vld && bus.req[idx[ID_W-1:0]]) begin
        pick     = idx[ID_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    owner_req   = bus.req[owner];
    beat        = (state == BUSY) && owner_req && !bus.fifo_full;
    release_now = (state == BUSY) && (!owner_req || (beat && beat_cnt == LAST_BEAT));
    owner_inc   = (owner == LAST_ID) ? '0 : owner + ID_W'(1);
    gnt_c       = '0;
    data_c      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_W'(i)) begin
        gnt_c[i] = beat;
        if (state == BUSY) data_c = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.fifo_w_en = beat;
  assign bus.fifo_data = data_c;
  assign bus.busy      = (state == BUSY);
  assign bus.owner_id  = owner;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = BUSY;
      BUSY:    if (release_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_vld) begin
        owner    <= pick;
        beat_cnt <= '0;
      end
    end else if (release_now) begin
      rr_ptr <= owner_inc;
    end else if (beat) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

`ifdef ARB_STALL_CNT_EN
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      stall_cnt <= '0;
    end else if ((state == BUSY) && owner_req && bus.fifo_full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule
